// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and registers the returned word into IF/ID.
// Illegal (misaligned/out-of-range) next-PC values are never loaded; the stage parks in ERR instead.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 100,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        addr_err
);

    localparam logic [31:0] LP_DEPTH = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ipc;
    logic [31:0] r_ipc4;
    logic        r_valid;
    logic        r_err;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_ipc_nxt;
    logic [31:0] w_ipc4_nxt;
    logic        w_valid_nxt;
    logic        w_err_nxt;
    logic [32:0] w_pc_plus4;
    logic [32:0] w_redir_ext;

    // Bit 32 carries the wrap of pc+4, so a wrapped address is never mistaken for a legal one.
    function automatic logic f_legal(input logic [32:0] a);
        return (a[32] == 1'b0) && (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < LP_DEPTH);
    endfunction

    assign w_pc_plus4  = {1'b0, r_pc} + 33'd4;
    assign w_redir_ext = {1'b0, redirect_pc};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_ipc4_nxt  = r_ipc4;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        case (r_state)
            S_BOOT: begin
                if (f_legal({1'b0, RESET_PC})) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RUN: begin
                if (redirect) begin
                    w_instr_nxt = NOP_WORD;
                    w_valid_nxt = 1'b0;
                    if (f_legal(w_redir_ext)) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end else if (!stall) begin
                    // Current PC was legal when loaded, so its word is captured even if PC+4 is not.
                    w_instr_nxt = imem_rdata;
                    w_ipc_nxt   = r_pc;
                    w_ipc4_nxt  = w_pc_plus4[31:0];
                    w_valid_nxt = 1'b1;
                    if (f_legal(w_pc_plus4)) begin
                        w_pc_nxt = w_pc_plus4[31:0];
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_ERR: begin
                w_instr_nxt = NOP_WORD;
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = S_ERR;
                w_instr_nxt = NOP_WORD;
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= NOP_WORD;
            r_ipc   <= '0;
            r_ipc4  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
            r_ipc4  <= w_ipc4_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign imem_addr  = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_pc    = r_ipc;
    assign ifid_pc4   = r_ipc4;
    assign ifid_valid = r_valid;
    assign addr_err   = r_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: ROM model, abstract fetch model checked every cycle,
// directed scenarios with literal expectations, then randomized stall/redirect/reset traffic.
module tb_instruction_fetch;

    localparam int unsigned MEM_DEPTH = 100;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        addr_err;

    logic [31:0] rom [MEM_DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit          m_booted;
    bit          m_err;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (RESET_PC),
        .MEM_DEPTH(MEM_DEPTH),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .addr_err   (addr_err)
    );

    assign imem_rdata = (imem_addr[1:0] == 2'b00 && (imem_addr / 4) < MEM_DEPTH)
                        ? rom[imem_addr / 4] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input longint a);
        return (a >= 0) && (a % 4 == 0) && (a / 4 < longint'(MEM_DEPTH));
    endfunction

    task automatic model_reset();
        m_booted = 0;
        m_err    = 0;
        m_valid  = 0;
        m_pc     = RESET_PC;
        m_instr  = NOP_WORD;
        m_ipc    = '0;
        m_ipc4   = '0;
    endtask

    task automatic model_edge();
        longint nxt;
        if (!m_booted) begin
            m_booted = 1;
            if (!legal(longint'(RESET_PC))) m_err = 1;
        end else if (m_err) begin
            m_instr = NOP_WORD;
            m_valid = 0;
        end else if (redirect) begin
            m_instr = NOP_WORD;
            m_valid = 0;
            if (legal(longint'(redirect_pc))) m_pc = redirect_pc;
            else m_err = 1;
        end else if (!stall) begin
            m_instr = rom[m_pc / 4];
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_valid = 1;
            nxt     = longint'(m_pc) + 4;
            if (legal(nxt)) m_pc = 32'(nxt);
            else m_err = 1;
        end
    endtask

    always @(negedge rst_n) model_reset();

    // Single compare process: advance the model on each edge, compare 1 time unit later.
    always @(posedge clk) begin
        if (rst_n) model_edge();
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("ifid_instr", ifid_instr, m_instr);
        chk("addr_err", 32'(addr_err), 32'(m_err));
        if (m_valid) begin
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_pc4", ifid_pc4, m_ipc4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_instr", ifid_instr, NOP_WORD);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic seq_rom();
        for (int unsigned i = 0; i < MEM_DEPTH; i++) rom[i] = 32'(i + 1);
    endtask

    task automatic test_boot_seq(input string tag);
        tick();
        chk({tag, "_boot_valid"}, 32'(ifid_valid), 32'h0);
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk({tag, "_instr"}, ifid_instr, 32'(k + 1));
            chk({tag, "_pc"}, ifid_pc, 32'(4 * k));
            chk({tag, "_pc4"}, ifid_pc4, 32'(4 * k + 4));
        end
    endtask

    int unsigned r;

    initial begin
        model_reset();
        seq_rom();
        #12;
        do_reset();

        // Boot and first three sequential fetches
        test_boot_seq("t1");

        // Stall at pc=8 (after the third capture, imem_addr is 12; redirect back to 8 first)
        chk("t2_pre_addr", imem_addr, 32'd12);
        redirect = 1'b1; redirect_pc = 32'd8;
        tick();
        redirect = 1'b0;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_stall_addr", imem_addr, 32'd12);
            chk("t2_stall_pc", ifid_pc, 32'd8);
        end
        stall = 1'b0;
        tick();
        chk("t2_release_pc", ifid_pc, 32'd12);
        chk("t2_release_instr", ifid_instr, 32'd4);

        // Redirect wins over stall
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick();
        chk("t3_addr", imem_addr, 32'h40);
        chk("t3_valid", 32'(ifid_valid), 32'h0);
        chk("t3_instr", ifid_instr, NOP_WORD);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk("t3_pc", ifid_pc, 32'h40);
        chk("t3_instr2", ifid_instr, 32'd17);

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        chk("t4_err", 32'(addr_err), 32'h1);
        chk("t4_addr", imem_addr, 32'h44);
        for (int k = 0; k < 3; k++) begin
            stall = k[0];
            tick();
            chk("t4_valid", 32'(ifid_valid), 32'h0);
            chk("t4_addr_hold", imem_addr, 32'h44);
        end
        stall = 1'b0;

        // Run off the end of the ROM
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'd380;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t5_instr", ifid_instr, 32'd100);
        chk("t5_pc", ifid_pc, 32'd396);
        chk("t5_err", 32'(addr_err), 32'h1);
        chk("t5_addr", imem_addr, 32'd396);
        tick();
        chk("t5_valid", 32'(ifid_valid), 32'h0);
        chk("t5_addr_hold", imem_addr, 32'd396);

        // Mid-stream asynchronous reset, then restart identical to the first sequence
        do_reset();
        tick(); tick(); tick();
        #1;
        do_reset();
        test_boot_seq("t6");

        // Randomized traffic
        for (int unsigned i = 0; i < MEM_DEPTH; i++) rom[i] = $urandom;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            stall    = ($urandom_range(0, 99) < 25);
            redirect = ($urandom_range(0, 99) < 10);
            r = $urandom_range(0, 19);
            if (r < 15)      redirect_pc = 32'($urandom_range(0, MEM_DEPTH - 1)) * 4;
            else if (r < 17) redirect_pc = 32'($urandom_range(0, MEM_DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (r < 19) redirect_pc = 32'(MEM_DEPTH) * 4 + 32'($urandom_range(0, 1000)) * 4;
            else             redirect_pc = $urandom;
            tick();
            if ((addr_err && $urandom_range(0, 3) == 0) || (c % 200 == 199)) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
